count_1_sched: RTL and testbench
================================

# count_1_sched

Frame-level scheduler that shares one `count_1` population-count datapath between `N_REQ` requesters. Each requester streams a frame of `IN_LEN`-bit words, terminated by a last flag. The scheduler grants one whole frame at a time in round-robin order and feeds the granted words through the shared `count_1` instance. It accumulates the per-word one-counts and returns the frame total, tagged with the requester id, over a valid/ready output handshake.

## Interface
- `N_REQ`, 4, number of requesters; must be at least 2.
- `IN_LEN`, 32, word width fed to `count_1`.
- `OUT_LEN`, 6, `count_1` result width; must be at least clog2(`IN_LEN`+1).
- `ACC_LEN`, 16, frame accumulator width.
- `ID_LEN`, 2, requester id width; must equal clog2(`N_REQ`).

- `sys_clk`  in  1  single clock; all state changes on its rising edge.
- `in_rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  `N_REQ`  per-requester word valid.
- `req_last`  in  `N_REQ`  per-requester last word of frame; qualified by valid.
- `req_dat`  in  `N_REQ`*`IN_LEN`  requester i word at bits [i*`IN_LEN` +: `IN_LEN`].
- `req_ready`  out  `N_REQ`  per-requester word accepted.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  result consumer ready.
- `out_id`  out  `ID_LEN`  requester index of the result.
- `out_sum`  out  `ACC_LEN`  total ones in the frame.
- `out_ovf`  out  1  accumulator saturated during the frame.

## Operation
- One internal `count_1` instance (`IN_LEN`, `OUT_LEN`). Its input is muxed from `req_dat` of the granted requester.
- State machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - If any `req_valid` is high, pick the first requester with valid set, searching from `ptr`+1 upward and wrapping modulo `N_REQ`.
  - Register the pick as `gnt`, clear `acc` and `ovf`, and go to RUN.
  - If no `req_valid` is high, stay in IDLE.
- **RUN**
  - `req_ready[gnt]` = 1. Every other `req_ready` bit = 0.
  - On `req_valid[gnt]` & ready: `acc` <= sat(`acc` + zero-extended `count_1` result).
  - If the sum exceeds 2^`ACC_LEN`-1, `acc` is clamped to that value and `ovf` <= 1. `ovf` is sticky for the frame.
  - If `req_last[gnt]` is set on an accepted word, go to DONE.
  - If `req_valid[gnt]` is low, stay in RUN, accept nothing and keep `acc`. There is no timeout.
- **DONE**
  - `out_valid` = 1, with `out_id` = `gnt`, `out_sum` = `acc`, `out_ovf` = `ovf`, all held stable.
  - On `out_ready`: `ptr` <= `gnt` and go to IDLE.
- Valid/last from requesters that are not granted are ignored. `req_valid`/`req_last` of the granted requester are ignored outside RUN.
- `req_ready` is a function of state and `gnt` only, never of `req_valid`.

## Timing
- Reset values:
  - state = IDLE, `gnt` = 0, `ptr` = `N_REQ`-1 (requester 0 has first priority), `acc` = 0, `ovf` = 0.
  - `req_ready` = 0, `out_valid` = 0, `out_id` = 0, `out_sum` = 0, `out_ovf` = 0.
- Grant latency: `req_valid` seen high in IDLE at edge k gives `req_ready[gnt]` = 1 from k+1.
- Throughput in RUN is one word per cycle.
- A frame of W words with valid held high:
  - IDLE 1 cycle, RUN W cycles.
  - `out_valid` rises the cycle after the last accept.
  - With `out_ready` held at 1, the next grant is 3 cycles after the previous last word.
- Single-word frame (valid and last on the first word) is legal. Result = that word's popcount.
- Word with value zero: accepted, `acc` unchanged.
- Reset asserted mid-frame or in DONE returns everything to reset values immediately. The partial frame is discarded and no result is produced.
- `out_valid` stays high until `out_ready`. No requester is granted while a result is pending.

## Test plan
- **Basic frame.** Reset, then requester 0 sends 0xFFFFFFFF, 0x0000000F, then last 0x00000001. Required: `req_ready[0]` on 3 cycles, then `out_valid` with `out_id` = 0, `out_sum` = 37, `out_ovf` = 0.
- **Round-robin.** All 4 requesters hold single-word frames of 0x1 at once, `out_ready` = 1. Required: `out_id` sequence 0, 1, 2, 3, 0. Results spaced 3 cycles apart. A non-granted `req_ready` is never high.
- **Stall in RUN.**
  - Requester 2 sends 0xF0F0F0F0, drops `req_valid` for 5 cycles, then sends last 0x3.
  - Required: no accept during the gap, `out_sum` = 18, `out_id` = 2.
- **Back-pressure.** Hold `out_ready` = 0 for 10 cycles after `out_valid` while requester 1 is valid. Required: `out_*` stable, `req_ready` all 0, and requester 1 is granted only after the `out_ready` handshake.
- **Saturation.** With `ACC_LEN` = 8, requester 3 sends nine words of 0xFFFFFFFF, the last flagged. Required: `out_sum` = 255, `out_ovf` = 1. The next frame (0x1) gives `out_sum` = 1, `out_ovf` = 0.
- **Reset mid-frame.**
  - Assert `in_rst_n` = 0 after 2 of 4 words of requester 1's frame.
  - Required: outputs immediately at reset values, no `out_valid` for the aborted frame.
  - After release, requester 0 wins over 1 when both are valid.

Source files
------------

// File: rtl/count_1_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_1_sched : round-robin frame scheduler around one shared count_1    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module count_1 #(
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 6
) (
  input  logic [IN_LEN-1:0]  i_dat,
  output logic [OUT_LEN-1:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < IN_LEN; i++) begin
      o_cnt = o_cnt + OUT_LEN'(i_dat[i]);
    end
  end
endmodule

module count_1_sched #(
  parameter int N_REQ   = 4,
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 6,
  parameter int ACC_LEN = 16,
  parameter int ID_LEN  = 2
) (
  input  logic                    sys_clk,
  input  logic                    in_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*IN_LEN-1:0] req_dat,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_LEN-1:0]       out_id,
  output logic [ACC_LEN-1:0]      out_sum,
  output logic                    out_ovf
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ID_LEN-1:0] c_ptr_rst = ID_LEN'(N_REQ - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_LEN-1:0]   r_gnt;
  logic [ID_LEN-1:0]   r_ptr;
  logic [ACC_LEN-1:0]  r_acc;
  logic                r_ovf;
  logic [ID_LEN-1:0]   w_pick;
  logic                w_any;
  logic                w_accept;
  logic [IN_LEN-1:0]   w_word;
  logic [OUT_LEN-1:0]  w_cnt;
  logic [ACC_LEN:0]    w_sum;
  logic                w_sat;

  // Walk offsets from far to near so the nearest valid requester after ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_any  = 1'b1;
        w_pick = ID_LEN'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_word   = req_dat[r_gnt*IN_LEN +: IN_LEN];
  assign w_accept = (r_state == S_RUN) && req_valid[r_gnt];

  count_1 #(
    .IN_LEN  (IN_LEN),
    .OUT_LEN (OUT_LEN)
  ) u_count_1 (
    .i_dat (w_word),
    .o_cnt (w_cnt)
  );

  assign w_sum = {1'b0, r_acc} + (ACC_LEN+1)'(w_cnt);
  assign w_sat = w_sum[ACC_LEN];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && req_last[r_gnt]) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= c_ptr_rst;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt <= w_pick;
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_acc <= w_sat ? {ACC_LEN{1'b1}} : w_sum[ACC_LEN-1:0];
            if (w_sat) r_ovf <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_ptr <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_RUN) req_ready[r_gnt] = 1'b1;
  end

  assign out_valid = (r_state == S_DONE);
  assign out_id    = out_valid ? r_gnt : '0;
  assign out_sum   = out_valid ? r_acc : '0;
  assign out_ovf   = out_valid & r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_count_1_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_count_1_sched : scoreboard bench, 16-bit and 8-bit accumulator DUTs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_count_1_sched;
  localparam int N_REQ = 4;

  logic         sys_clk = 1'b0;
  logic         in_rst_n;
  logic [3:0]   req_valid, req_last;
  logic [127:0] req_dat;
  logic         out_ready;
  logic [3:0]   rdy_a, rdy_b;
  logic         ov_a, ov_b, of_a, of_b;
  logic [1:0]   id_a, id_b;
  logic [15:0]  sum_a;
  logic [7:0]   sum_b;

  always #5 sys_clk = ~sys_clk;

  count_1_sched #(.N_REQ(4), .IN_LEN(32), .OUT_LEN(6), .ACC_LEN(16), .ID_LEN(2)) u_dut_a (
    .sys_clk(sys_clk), .in_rst_n(in_rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_dat(req_dat), .req_ready(rdy_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_id(id_a), .out_sum(sum_a), .out_ovf(of_a));

  count_1_sched #(.N_REQ(4), .IN_LEN(32), .OUT_LEN(6), .ACC_LEN(8), .ID_LEN(2)) u_dut_b (
    .sys_clk(sys_clk), .in_rst_n(in_rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_dat(req_dat), .req_ready(rdy_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_id(id_b), .out_sum(sum_b), .out_ovf(of_b));

  typedef struct { logic [31:0] dat; logic last; int gap; } word_t;
  typedef struct { logic [1:0] id; logic [15:0] s16; logic o16; logic [7:0] s8; logic o8; } res_t;
  typedef struct { int id; int n; logic [31:0] w0, w1, w2; int gap;
                   logic [15:0] s16; logic o16; logic [7:0] s8; logic o8; } vec_t;

  word_t q[N_REQ][$];
  res_t  exp_q[$];
  int    res_cyc_q[$];
  vec_t  tbl[5];

  int checks = 0, failures = 0, cyc = 0;
  int acc_cnt[N_REQ];
  int last_acc_cyc = 0;
  logic hold = 1'b0;
  logic [1:0] h_id;
  logic [15:0] h_sum;
  logic h_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
      req_dat[i*32 +: 32] = '0;
      if (q[i].size() > 0) begin
        word_t w;
        w = q[i][0];
        if (w.gap > 0) begin
          w.gap = w.gap - 1;
          q[i][0] = w;
        end else begin
          req_valid[i] = 1'b1;
          req_last[i]  = w.last;
          req_dat[i*32 +: 32] = w.dat;
        end
      end
    end
  endtask

  // One clock: sample/check at negedge, advance stimulus just after posedge.
  task automatic step();
    logic [3:0] mask;
    @(negedge sys_clk);
    cyc++;
    mask = req_valid & rdy_a;
    check("ready_onehot", 32'($countones(rdy_a) <= 1), 1);
    for (int i = 0; i < N_REQ; i++) if (mask[i]) begin acc_cnt[i]++; last_acc_cyc = cyc; end
    if (hold) begin
      check("hold_valid", 32'(ov_a), 1);
      check("hold_id", 32'(id_a), 32'(h_id));
      check("hold_sum", 32'(sum_a), 32'(h_sum));
      check("hold_ovf", 32'(of_a), 32'(h_ovf));
    end
    hold = ov_a && !out_ready;
    h_id = id_a; h_sum = sum_a; h_ovf = of_a;
    if (ov_a && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual_id=%0d actual_sum=%0d required=none", id_a, sum_a);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_id", 32'(id_a), 32'(e.id));
        check("res_sum16", 32'(sum_a), 32'(e.s16));
        check("res_ovf16", 32'(of_a), 32'(e.o16));
        check("res_valid8", 32'(ov_b), 1);
        check("res_id8", 32'(id_b), 32'(e.id));
        check("res_sum8", 32'(sum_b), 32'(e.s8));
        check("res_ovf8", 32'(of_b), 32'(e.o8));
      end
      res_cyc_q.push_back(cyc);
    end
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N_REQ; i++) if (mask[i]) void'(q[i].pop_front());
    drive();
  endtask

  function automatic logic busy();
    logic b;
    b = (exp_q.size() != 0);
    for (int i = 0; i < N_REQ; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin step(); n++; end
    if (busy()) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
      exp_q.delete();
      for (int i = 0; i < N_REQ; i++) q[i].delete();
    end
  endtask

  task automatic push_word(input int id, input logic [31:0] d, input logic l, input int g);
    word_t w;
    w.dat = d; w.last = l; w.gap = g;
    q[id].push_back(w);
  endtask

  task automatic push_exp(input int id, input logic [15:0] s16, input logic o16,
                          input logic [7:0] s8, input logic o8);
    res_t r;
    r.id = 2'(id); r.s16 = s16; r.o16 = o16; r.s8 = s8; r.o8 = o8;
    exp_q.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_a"}, 32'(rdy_a), 0);
    check({tag, "_valid_a"}, 32'(ov_a), 0);
    check({tag, "_id_a"}, 32'(id_a), 0);
    check({tag, "_sum_a"}, 32'(sum_a), 0);
    check({tag, "_ovf_a"}, 32'(of_a), 0);
    check({tag, "_rdy_b"}, 32'(rdy_b), 0);
    check({tag, "_valid_b"}, 32'(ov_b), 0);
    check({tag, "_sum_b"}, 32'(sum_b), 0);
  endtask

  task automatic set_vec(input int k, input int id, input int n, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input int gap,
                         input logic [15:0] s16, input logic o16, input logic [7:0] s8, input logic o8);
    tbl[k].id = id; tbl[k].n = n; tbl[k].w0 = w0; tbl[k].w1 = w1; tbl[k].w2 = w2;
    tbl[k].gap = gap; tbl[k].s16 = s16; tbl[k].o16 = o16; tbl[k].s8 = s8; tbl[k].o8 = o8;
  endtask

  initial begin
    set_vec(0, 0, 3, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0001, 0, 16'd37, 1'b0, 8'd37, 1'b0);
    set_vec(1, 2, 2, 32'hF0F0_F0F0, 32'h0000_0003, 32'h0, 5, 16'd18, 1'b0, 8'd18, 1'b0);
    set_vec(2, 1, 1, 32'h0000_0000, 32'h0, 32'h0, 0, 16'd0, 1'b0, 8'd0, 1'b0);
    set_vec(3, 3, 3, 32'h8000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 0, 16'd33, 1'b0, 8'd33, 1'b0);
    set_vec(4, 3, 1, 32'h0000_FFFF, 32'h0, 32'h0, 0, 16'd16, 1'b0, 8'd16, 1'b0);

    in_rst_n = 1'b0; out_ready = 1'b1;
    req_valid = '0; req_last = '0; req_dat = '0;
    for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    in_rst_n = 1'b1;

    // Single-requester frames from the table
    for (int k = 0; k < 5; k++) begin
      int first;
      for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
      for (int j = 0; j < tbl[k].n; j++) begin
        logic [31:0] d;
        d = (j == 0) ? tbl[k].w0 : (j == 1) ? tbl[k].w1 : tbl[k].w2;
        push_word(tbl[k].id, d, j == tbl[k].n - 1,
                  (j == tbl[k].n - 1 && j > 0) ? tbl[k].gap : 0);
      end
      push_exp(tbl[k].id, tbl[k].s16, tbl[k].o16, tbl[k].s8, tbl[k].o8);
      first = res_cyc_q.size();
      wait_done("table", 60);
      check("table_accepts", 32'(acc_cnt[tbl[k].id]), 32'(tbl[k].n));
      if (res_cyc_q.size() > first)
        check("done_latency", 32'(res_cyc_q[first] - last_acc_cyc), 1);
      else begin
        checks++; failures++;
        $display("FAIL done_latency actual=no_result required=1");
      end
    end

    // Round-robin: 0,1,2,3 then 0 again, 3 cycles apart
    res_cyc_q.delete();
    push_word(0, 32'h1, 1'b1, 0);
    push_word(0, 32'h1, 1'b1, 0);
    for (int i = 1; i < N_REQ; i++) push_word(i, 32'h1, 1'b1, 0);
    for (int i = 0; i < 5; i++) push_exp(i % 4, 16'd1, 1'b0, 8'd1, 1'b0);
    wait_done("rr", 60);
    check("rr_results", 32'(res_cyc_q.size()), 5);
    for (int i = 1; i < res_cyc_q.size(); i++)
      check("rr_spacing", 32'(res_cyc_q[i] - res_cyc_q[i-1]), 3);

    // Back-pressure: result held, requester 1 waits for the handshake
    for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
    out_ready = 1'b0;
    push_word(0, 32'h5, 1'b1, 0);
    push_exp(0, 16'd2, 1'b0, 8'd2, 1'b0);
    begin
      int n;
      n = 0;
      while (!ov_a && n < 20) begin step(); n++; end
      check("bp_valid", 32'(ov_a), 1);
    end
    push_word(1, 32'h3, 1'b1, 0);
    push_exp(1, 16'd2, 1'b0, 8'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_ready_low", 32'(rdy_a), 0);
    end
    check("bp_no_accept", 32'(acc_cnt[1]), 0);
    out_ready = 1'b1;
    wait_done("bp", 40);
    check("bp_accept_after", 32'(acc_cnt[1]), 1);

    // Saturation: 9 x 32 ones; 8-bit accumulator clamps
    for (int j = 0; j < 9; j++) push_word(3, 32'hFFFF_FFFF, j == 8, 0);
    push_exp(3, 16'd288, 1'b0, 8'd255, 1'b1);
    wait_done("sat", 60);
    push_word(3, 32'h1, 1'b1, 0);
    push_exp(3, 16'd1, 1'b0, 8'd1, 1'b0);
    wait_done("sat_next", 30);

    // Reset after 2 of 4 words; aborted frame must produce nothing
    for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
    for (int j = 0; j < 4; j++) push_word(1, 32'h1, j == 3, 0);
    begin
      int n;
      n = 0;
      while (acc_cnt[1] < 2 && n < 20) begin step(); n++; end
      check("mid_accepts", 32'(acc_cnt[1]), 2);
    end
    in_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < N_REQ; i++) q[i].delete();
    hold = 1'b0;
    drive();
    step();
    step();
    in_rst_n = 1'b1;
    push_word(0, 32'h1, 1'b1, 0);
    push_word(1, 32'h3, 1'b1, 0);
    push_exp(0, 16'd1, 1'b0, 8'd1, 1'b0);
    push_exp(1, 16'd2, 1'b0, 8'd2, 1'b0);
    wait_done("post_rst", 40);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
